lcd_ctrl: RTL and testbench
===========================

Name: lcd_ctrl

Overview:
- Downstream consumer of the LSU's LCD control register (address 0x7030, 32-bit register output).
- Converts each software-issued request into one correctly timed HD44780-style 8-bit write cycle on the LCD pins (RS, RW, EN, DATA).
- Provides a busy flag and a transfer counter; the flag is wired back into the LSU read mux as a status input.

Parameters:
- SETUP_CYC, 3, cycles RS/DATA stable before EN rises (tAS).
- EN_CYC, 25, cycles EN held high (≥450 ns at 50 MHz).
- HOLD_CYC, 3, cycles RS/DATA held after EN falls (tH).
- CMD_WAIT_CYC, 2000, post-write wait for normal commands and data (40 µs).
- CLR_WAIT_CYC, 82000, post-write wait for clear/home commands (1.64 ms).

Ports:
- i_clk  in  1  system clock
- i_rst_n  in  1  synchronous, active-low reset
- i_lcd_reg  in  32  LCD register from LSU: [31] ON, [30] REQ toggle, [8] RS, [7:0] DATA; other bits ignored
- o_lcd_on  out  1  LCD power/backlight
- o_lcd_rs  out  1  register select
- o_lcd_rw  out  1  read/write, constant 0
- o_lcd_en  out  1  enable strobe
- o_lcd_data  out  8  LCD data bus
- o_busy  out  1  transfer pending or in progress
- o_xfer_cnt  out  8  completed-transfer count, wraps

Behaviour:
- Clock and reset: one clock, i_clk. Reset is synchronous, active-low (i_rst_n), sampled on the i_clk rising edge.
- Reset values: state=IDLE; req_ack=0; o_lcd_on=0; o_lcd_rs=0; o_lcd_rw=0; o_lcd_en=0; o_lcd_data=0; o_xfer_cnt=0; cycle counter=0.
- Reset mid-operation: the block aborts at the next edge, EN drops to 0, and no partial-transfer count is recorded.
- o_lcd_on: i_lcd_reg[31] registered, one-cycle latency, independent of the FSM.
- Request rule: a pending request exists when i_lcd_reg[30] != req_ack.
- o_busy: combinational = (state != IDLE) | (i_lcd_reg[30] != req_ack). It is visible in the same cycle the LSU register updates.
- Launch: in IDLE with a pending request, at that edge:
  - req_ack <= i_lcd_reg[30];
  - RS and DATA are latched into o_lcd_rs and o_lcd_data;
  - the wait type is latched: clear/home = (RS==0 && DATA[7:2]==0 && DATA[1:0]!=0);
  - state <= SETUP.
- FSM, using one down-counter loaded on each state entry:
  - IDLE: EN=0; outputs hold the last values.
  - SETUP: EN=0 for SETUP_CYC cycles, then PULSE.
  - PULSE: EN=1 for EN_CYC cycles, then HOLD.
  - HOLD: EN=0 for HOLD_CYC cycles; RS and DATA unchanged; then WAIT.
  - WAIT: EN=0 for CLR_WAIT_CYC (clear/home) or CMD_WAIT_CYC (all others). On the last cycle, o_xfer_cnt increments (255→0) and state goes to IDLE.
- Latency:
  - EN rises exactly SETUP_CYC+1 edges after the launch edge.
  - Total non-IDLE cycles = SETUP_CYC+EN_CYC+HOLD_CYC+WAIT.
  - A new launch can occur on the first IDLE cycle (back-to-back requests have no dead cycle beyond the IDLE sample).
- EN and DATA registers are glitch-free: all LCD outputs come directly from flops.
- Changes to i_lcd_reg[8:0] after launch are ignored until the next launch.
- Request toggles during a transfer:
  - An odd number of toggles leaves one pending request, serviced using the register contents present at the next launch.
  - An even number of toggles cancels.
  - Software must poll o_busy before toggling; lost requests are not flagged.
- Counter width: ceil(log2(CLR_WAIT_CYC+1)) bits. All parameters must be ≥1.
- A request pending at reset release (i_lcd_reg[30]=1) launches on the first post-reset IDLE cycle.

Test Plan:
- Common bench parameters: SETUP=2, EN=4, HOLD=2, CMD_WAIT=10, CLR_WAIT=40.
- Reset, then i_lcd_reg=0x8000_0000 → o_lcd_on=1 one edge later; o_busy=0, o_lcd_en=0, o_xfer_cnt=0.
- Write {REQ=1, RS=1, DATA=0x41} → o_busy=1 immediately; RS=1, DATA=0x41 from the next edge; EN high for exactly 4 cycles starting 3 edges after launch; busy for 18 cycles; o_xfer_cnt=1.
- Command 0x01 (RS=0) → WAIT lasts 40 cycles (busy 48 cycles). Command 0x38 → WAIT 10 cycles (busy 18 cycles).
- While busy:
  - change DATA to 0x42 without toggling → no effect, waveform unchanged;
  - toggle REQ once → a second transfer with 0x42 launches in the first IDLE cycle;
  - toggle twice → no second transfer.
- Deassert i_rst_n during PULSE → next edge EN=0, state IDLE, o_xfer_cnt unchanged; the mismatch left by reset (req_ack=0, REQ bit=1) relaunches after release.
- Run 256 transfers → o_xfer_cnt wraps from 255 to 0; RW stays 0 throughout.

Source files
------------

// File: rtl/lcd_ctrl.sv
// lcd_ctrl: turns each toggle of the LSU LCD register's REQ bit into one
// HD44780-style 8-bit write cycle (RS/DATA setup, EN pulse, hold, settle wait).
// The busy flag and the wrapping transfer counter are read back through the LSU.
module lcd_ctrl #(
  parameter int unsigned SETUP_CYC    = 32'd3,
  parameter int unsigned EN_CYC       = 32'd25,
  parameter int unsigned HOLD_CYC     = 32'd3,
  parameter int unsigned CMD_WAIT_CYC = 32'd2000,
  parameter int unsigned CLR_WAIT_CYC = 32'd82000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_lcd_reg,
  output logic        o_lcd_on,
  output logic        o_lcd_rs,
  output logic        o_lcd_rw,
  output logic        o_lcd_en,
  output logic [7:0]  o_lcd_data,
  output logic        o_busy,
  output logic [7:0]  o_xfer_cnt
);

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Clear display (0x01) and return home (0x02/0x03) need the long settle time.
  function automatic logic is_clr_home(input logic rs, input logic [7:0] data);
    return (rs == 1'b0) && (data[7:2] == 6'd0) && (data[1:0] != 2'd0);
  endfunction

  localparam int unsigned MAX_CYC = max2(max2(max2(SETUP_CYC, EN_CYC),
                                              max2(HOLD_CYC, CMD_WAIT_CYC)),
                                         CLR_WAIT_CYC);
  localparam int unsigned CNT_W = $clog2(MAX_CYC + 32'd1);

  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(32'd1);
  localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYC - 32'd1);
  localparam logic [CNT_W-1:0] EN_LD     = CNT_W'(EN_CYC - 32'd1);
  localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYC - 32'd1);
  localparam logic [CNT_W-1:0] CMD_WT_LD = CNT_W'(CMD_WAIT_CYC - 32'd1);
  localparam logic [CNT_W-1:0] CLR_WT_LD = CNT_W'(CLR_WAIT_CYC - 32'd1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_PULSE = 3'd2,
    S_HOLD  = 3'd3,
    S_WAIT  = 3'd4
  } state_t;

  state_t           state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic             req_ack_r, req_ack_s;
  logic             lcd_rs_r, lcd_rs_s;
  logic [7:0]       lcd_data_r, lcd_data_s;
  logic             lcd_en_r, lcd_en_s;
  logic             clr_r, clr_s;
  logic [7:0]       xfer_cnt_r, xfer_cnt_s;
  logic             lcd_on_r;
  logic             pending_s;
  logic             unused_s;

  // Bits of the LSU register that carry no meaning for this block.
  assign unused_s = ^{i_lcd_reg[29:9]};

  // A request is pending whenever software's REQ bit differs from our acknowledge.
  assign pending_s = i_lcd_reg[30] ^ req_ack_r;

  // Next-state logic: one down-counter reloaded on every state entry.
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    req_ack_s  = req_ack_r;
    lcd_rs_s   = lcd_rs_r;
    lcd_data_s = lcd_data_r;
    clr_s      = clr_r;
    xfer_cnt_s = xfer_cnt_r;
    // EN follows PULSE one cycle late, giving RS/DATA SETUP_CYC+1 cycles of setup.
    lcd_en_s   = (state_r == S_PULSE);
    case (state_r)
      S_IDLE: begin
        if (pending_s) begin
          req_ack_s  = i_lcd_reg[30];
          lcd_rs_s   = i_lcd_reg[8];
          lcd_data_s = i_lcd_reg[7:0];
          clr_s      = is_clr_home(i_lcd_reg[8], i_lcd_reg[7:0]);
          cnt_s      = SETUP_LD;
          state_s    = S_SETUP;
        end else begin
          state_s    = S_IDLE;
        end
      end
      S_SETUP: begin
        if (cnt_r == CNT_ZERO) begin
          cnt_s   = EN_LD;
          state_s = S_PULSE;
        end else begin
          cnt_s   = cnt_r - CNT_ONE;
        end
      end
      S_PULSE: begin
        if (cnt_r == CNT_ZERO) begin
          cnt_s   = HOLD_LD;
          state_s = S_HOLD;
        end else begin
          cnt_s   = cnt_r - CNT_ONE;
        end
      end
      S_HOLD: begin
        if (cnt_r == CNT_ZERO) begin
          cnt_s   = clr_r ? CLR_WT_LD : CMD_WT_LD;
          state_s = S_WAIT;
        end else begin
          cnt_s   = cnt_r - CNT_ONE;
        end
      end
      S_WAIT: begin
        if (cnt_r == CNT_ZERO) begin
          xfer_cnt_s = xfer_cnt_r + 8'd1;
          state_s    = S_IDLE;
        end else begin
          cnt_s      = cnt_r - CNT_ONE;
        end
      end
      default: begin
        cnt_s   = CNT_ZERO;
        state_s = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any transfer without counting it.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_r    <= S_IDLE;
      cnt_r      <= CNT_ZERO;
      req_ack_r  <= 1'b0;
      lcd_rs_r   <= 1'b0;
      lcd_data_r <= 8'd0;
      lcd_en_r   <= 1'b0;
      clr_r      <= 1'b0;
      xfer_cnt_r <= 8'd0;
      lcd_on_r   <= 1'b0;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      req_ack_r  <= req_ack_s;
      lcd_rs_r   <= lcd_rs_s;
      lcd_data_r <= lcd_data_s;
      lcd_en_r   <= lcd_en_s;
      clr_r      <= clr_s;
      xfer_cnt_r <= xfer_cnt_s;
      lcd_on_r   <= i_lcd_reg[31];
    end
  end

  assign o_lcd_on   = lcd_on_r;
  assign o_lcd_rs   = lcd_rs_r;
  assign o_lcd_rw   = 1'b0;
  assign o_lcd_en   = lcd_en_r;
  assign o_lcd_data = lcd_data_r;
  assign o_xfer_cnt = xfer_cnt_r;
  // Busy must show in the same cycle the LSU writes a new request.
  assign o_busy     = (state_r != S_IDLE) | pending_s;

endmodule

// File: tb/tb_lcd_ctrl.sv
// tb_lcd_ctrl: directed stimulus pushes expected transfers into a queue; a
// pin monitor rebuilds each transfer from the LCD outputs and pops/compares
// whenever the completed-transfer counter moves.
module tb_lcd_ctrl;

  localparam int SETUP = 2;
  localparam int ENC   = 4;
  localparam int HOLD  = 2;
  localparam int CMDW  = 10;
  localparam int CLRW  = 40;

  // Reference point (busy rise / previous completion / reset release) to first
  // EN-high sample: one pending-sample cycle + SETUP + one EN register stage.
  localparam int PRE_EXP  = 4;
  localparam int EN_EXP   = 4;
  // First EN-low sample to counter change: HOLD + WAIT - 1.
  localparam int TAIL_CMD = 11;
  localparam int TAIL_CLR = 41;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic [31:0] i_lcd_reg;
  logic        o_lcd_on, o_lcd_rs, o_lcd_rw, o_lcd_en, o_busy;
  logic [7:0]  o_lcd_data, o_xfer_cnt;

  lcd_ctrl #(
    .SETUP_CYC(SETUP), .EN_CYC(ENC), .HOLD_CYC(HOLD),
    .CMD_WAIT_CYC(CMDW), .CLR_WAIT_CYC(CLRW)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_lcd_reg(i_lcd_reg),
    .o_lcd_on(o_lcd_on), .o_lcd_rs(o_lcd_rs), .o_lcd_rw(o_lcd_rw),
    .o_lcd_en(o_lcd_en), .o_lcd_data(o_lcd_data), .o_busy(o_busy),
    .o_xfer_cnt(o_xfer_cnt)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic       rs;
    logic [7:0] data;
    int         tail;
    logic [7:0] cnt;
  } exp_t;

  exp_t       exp_q[$];
  int         checks = 0;
  int         errors = 0;
  logic       req_bit = 1'b0;
  logic [7:0] exp_cnt = 8'd0;
  bit         rw_seen = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // Toggle REQ with new RS/DATA; optionally record the transfer it should cause.
  task automatic do_xfer(input logic rs, input logic [7:0] data, input int tail, input bit push);
    exp_t e;
    req_bit   = ~req_bit;
    i_lcd_reg = {1'b1, req_bit, 21'd0, rs, data};
    if (push) begin
      exp_cnt = exp_cnt + 8'd1;
      e.rs = rs; e.data = data; e.tail = tail; e.cnt = exp_cnt;
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_idle(input int budget);
    bit done = 1'b0;
    for (int n = 0; n < budget && !done; n++) begin
      @(negedge i_clk);
      if (!o_busy) done = 1'b1;
    end
    check("idle_within_budget", {31'd0, done}, 32'd1);
  endtask

  // Pin monitor: reconstructs timing of each write cycle and scores it.
  int         t_now = 0, t_ref = 0, t_rise = 0, t_fall = 0;
  int         m_pre, m_en, m_tail;
  bit         rst_seen = 1'b0, en_prev = 1'b0, busy_prev = 1'b0;
  logic [7:0] last_cnt = 8'd0;
  logic       cap_rs;
  logic [7:0] cap_data;

  initial begin
    m_pre = -1; m_en = -1;
    forever begin
      @(negedge i_clk);
      t_now++;
      if (o_lcd_rw !== 1'b0) rw_seen = 1'b1;
      if (!i_rst_n) begin
        rst_seen = 1'b1;
        en_prev  = 1'b0;
        m_pre    = -1;
        m_en     = -1;
      end else if (rst_seen) begin
        rst_seen  = 1'b0;
        t_ref     = t_now;
        last_cnt  = o_xfer_cnt;
        en_prev   = o_lcd_en;
        busy_prev = o_busy;
      end else begin
        if (o_busy && !busy_prev) t_ref = t_now;
        if (o_lcd_en && !en_prev) begin
          t_rise   = t_now;
          m_pre    = t_now - t_ref;
          cap_rs   = o_lcd_rs;
          cap_data = o_lcd_data;
        end
        if (!o_lcd_en && en_prev) begin
          t_fall = t_now;
          m_en   = t_now - t_rise;
          check("hold_rs", {31'd0, o_lcd_rs}, {31'd0, cap_rs});
          check("hold_data", {24'd0, o_lcd_data}, {24'd0, cap_data});
        end
        if (o_xfer_cnt !== last_cnt) begin
          m_tail = t_now - t_fall;
          if (exp_q.size() == 0) begin
            check("unexpected_xfer", {24'd0, o_xfer_cnt}, {24'd0, last_cnt});
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("xfer_rs", {31'd0, cap_rs}, {31'd0, e.rs});
            check("xfer_data", {24'd0, cap_data}, {24'd0, e.data});
            check("xfer_setup", m_pre, PRE_EXP);
            check("xfer_en_len", m_en, EN_EXP);
            check("xfer_tail", m_tail, e.tail);
            check("xfer_cnt", {24'd0, o_xfer_cnt}, {24'd0, e.cnt});
          end
          m_pre    = -1;
          m_en     = -1;
          t_ref    = t_now;
          last_cnt = o_xfer_cnt;
        end
        en_prev   = o_lcd_en;
        busy_prev = o_busy;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    i_rst_n   = 1'b0;
    i_lcd_reg = 32'd0;
    repeat (3) @(posedge i_clk);
    #1 i_rst_n = 1'b1;
    @(negedge i_clk);
    check("rst_on", {31'd0, o_lcd_on}, 32'd0);
    check("rst_busy", {31'd0, o_busy}, 32'd0);
    check("rst_en", {31'd0, o_lcd_en}, 32'd0);
    check("rst_cnt", {24'd0, o_xfer_cnt}, 32'd0);
    check("rst_rs", {31'd0, o_lcd_rs}, 32'd0);
    check("rst_data", {24'd0, o_lcd_data}, 32'd0);

    // Power bit alone: one-edge latency, no transfer.
    step();
    i_lcd_reg = 32'h8000_0000;
    @(negedge i_clk);
    check("on_before_edge", {31'd0, o_lcd_on}, 32'd0);
    check("on_busy", {31'd0, o_busy}, 32'd0);
    @(negedge i_clk);
    check("on_after_edge", {31'd0, o_lcd_on}, 32'd1);
    check("on_en", {31'd0, o_lcd_en}, 32'd0);

    // Reset during PULSE: EN drops, nothing counted, REQ mismatch relaunches.
    step();
    do_xfer(1'b1, 8'h30, TAIL_CMD, 1'b0);
    repeat (4) @(posedge i_clk);
    @(negedge i_clk);
    check("abort_en_high", {31'd0, o_lcd_en}, 32'd1);
    step();
    i_rst_n = 1'b0;
    exp_cnt = 8'd0;
    step();
    i_rst_n = 1'b1;
    @(negedge i_clk);
    check("abort_en_low", {31'd0, o_lcd_en}, 32'd0);
    check("abort_cnt", {24'd0, o_xfer_cnt}, 32'd0);
    check("abort_busy", {31'd0, o_busy}, 32'd1);
    begin
      exp_t e;
      exp_cnt = 8'd1;
      e.rs = 1'b1; e.data = 8'h30; e.tail = TAIL_CMD; e.cnt = exp_cnt;
      exp_q.push_back(e);
    end
    wait_idle(120);

    // Data write 0x41: busy immediately, pins change at the launch edge.
    step();
    do_xfer(1'b1, 8'h41, TAIL_CMD, 1'b1);
    #1;
    check("busy_immediate", {31'd0, o_busy}, 32'd1);
    @(negedge i_clk);
    check("pre_launch_data", {24'd0, o_lcd_data}, 32'h30);
    @(negedge i_clk);
    check("launch_rs", {31'd0, o_lcd_rs}, 32'd1);
    check("launch_data", {24'd0, o_lcd_data}, 32'h41);
    wait_idle(120);

    // Clear display uses the long wait.
    step();
    do_xfer(1'b0, 8'h01, TAIL_CLR, 1'b1);
    wait_idle(120);

    // Function-set command, with DATA changed mid-transfer and no toggle.
    step();
    do_xfer(1'b0, 8'h38, TAIL_CMD, 1'b1);
    step();
    step();
    i_lcd_reg[7:0] = 8'h42;
    wait_idle(120);
    check("nochange_data", {24'd0, o_lcd_data}, 32'h38);
    check("nochange_rs", {31'd0, o_lcd_rs}, 32'd0);

    // Single toggle while busy: back-to-back second transfer.
    step();
    do_xfer(1'b1, 8'h41, TAIL_CMD, 1'b1);
    repeat (5) step();
    do_xfer(1'b1, 8'h42, TAIL_CMD, 1'b1);
    wait_idle(120);

    // Double toggle while busy: cancelled, no extra transfer.
    step();
    do_xfer(1'b1, 8'h43, TAIL_CMD, 1'b1);
    repeat (3) step();
    do_xfer(1'b1, 8'h44, TAIL_CMD, 1'b0);
    repeat (3) step();
    do_xfer(1'b1, 8'h45, TAIL_CMD, 1'b0);
    wait_idle(120);
    repeat (30) @(negedge i_clk);
    check("cancel_data", {24'd0, o_lcd_data}, 32'h43);
    check("cancel_cnt", {24'd0, o_xfer_cnt}, {24'd0, exp_cnt});

    // 256 transfers: counter wraps 255 -> 0 along the way.
    for (int i = 0; i < 256; i++) begin
      step();
      do_xfer(1'b1, 8'(i), TAIL_CMD, 1'b1);
      wait_idle(120);
    end

    repeat (5) @(negedge i_clk);
    check("queue_drained", exp_q.size(), 32'd0);
    check("rw_always_low", {31'd0, rw_seen}, 32'd0);
    check("final_cnt", {24'd0, o_xfer_cnt}, {24'd0, exp_cnt});
    check("final_busy", {31'd0, o_busy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
